// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a signed immediate into the RISC-V I/S/B/U/J
// field positions of a base instruction word, behind a two-stage pipeline.
module imm_encoder #(
   parameter int K     = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_imm,
   input  logic [K-1:0]     in_imm_sel,
   input  logic [31:0]      in_base,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [K-1:0] SEL_I = K'(0);
   localparam logic [K-1:0] SEL_S = K'(1);
   localparam logic [K-1:0] SEL_B = K'(2);
   localparam logic [K-1:0] SEL_U = K'(3);
   localparam logic [K-1:0] SEL_J = K'(4);

   logic        run;
   logic        a_valid;
   logic [31:0] a_instr;
   logic        a_err;
   logic        b_valid;
   logic [31:0] b_instr;
   logic        b_err;
   logic        b_free;
   logic        a_free;
   logic        in_xfer;
   logic        out_xfer;
   logic [31:0] enc_instr;
   logic        enc_err;
   logic        sext_11;
   logic        sext_12;
   logic        sext_20;

   // Sign-extension checks: all bits from the top down to the field's MSB agree.
   assign sext_11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign sext_12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
   assign sext_20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

   always_comb begin
      enc_instr = in_base;
      enc_err   = 1'b0;
      case (in_imm_sel)
         SEL_I: begin
            enc_instr[31:20] = in_imm[11:0];
            enc_err          = ~sext_11;
         end
         SEL_S: begin
            enc_instr[31:25] = in_imm[11:5];
            enc_instr[11:7]  = in_imm[4:0];
            enc_err          = ~sext_11;
         end
         SEL_B: begin
            enc_instr[31]    = in_imm[12];
            enc_instr[7]     = in_imm[11];
            enc_instr[30:25] = in_imm[10:5];
            enc_instr[11:8]  = in_imm[4:1];
            enc_err          = ~sext_12 | in_imm[0];
         end
         SEL_U: begin
            enc_instr[31:12] = in_imm[31:12];
            enc_err          = |in_imm[11:0];
         end
         SEL_J: begin
            enc_instr[31]    = in_imm[20];
            enc_instr[30:21] = in_imm[10:1];
            enc_instr[20]    = in_imm[11];
            enc_instr[19:12] = in_imm[19:12];
            enc_err          = ~sext_20 | in_imm[0];
         end
         default: enc_err = 1'b1;
      endcase
   end

   // run holds in_ready low until the first edge after reset release.
   assign b_free    = ~b_valid | out_ready;
   assign a_free    = ~a_valid | b_free;
   assign in_ready  = run & a_free;
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = b_valid & out_ready;
   assign out_valid = b_valid;
   assign out_instr = b_instr;
   assign out_err   = b_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run       <= 1'b0;
         a_valid   <= 1'b0;
         a_instr   <= '0;
         a_err     <= 1'b0;
         b_valid   <= 1'b0;
         b_instr   <= '0;
         b_err     <= 1'b0;
         err_count <= '0;
      end else begin
         run <= 1'b1;
         if (in_xfer) begin
            a_valid <= 1'b1;
            a_instr <= enc_instr;
            a_err   <= enc_err;
         end else if (b_free) begin
            a_valid <= 1'b0;
         end
         if (b_free) begin
            b_valid <= a_valid;
            if (a_valid) begin
               b_instr <= a_instr;
               b_err   <= a_err;
            end
         end
         if (out_xfer && b_err && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed table vectors, backpressure/saturation/reset sequences and a
// randomized encode/decode round trip for imm_encoder.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_imm;
   logic [2:0]  in_imm_sel;
   logic [31:0] in_base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   imm_encoder #(.K(3), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_imm_sel(in_imm_sel), .in_base(in_base),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] imm;
      logic [2:0]  sel;
      logic [31:0] base;
      logic [31:0] instr;
      logic        err;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference immediate generator (decoder side of the core).
   function automatic logic [31:0] decode(input logic [31:0] i, input logic [2:0] sel);
      case (sel)
         3'd0:    return {{20{i[31]}}, i[31:20]};
         3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
         3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3:    return {i[31:12], 12'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge with in_valid low.
   task automatic send(input logic [31:0] imm, input logic [2:0] sel, input logic [31:0] base);
      logic acc;
      int   n;
      acc = 1'b0;
      n = 0;
      in_valid = 1'b1; in_imm = imm; in_imm_sel = sel; in_base = base;
      while (!acc && n < 50) begin
         #1 acc = in_ready;
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   localparam int NRT = 5000;
   logic [31:0] rt_imm[NRT];
   logic [2:0]  rt_sel[NRT];
   logic [31:0] rt_base[NRT];
   int          exp_q[$];

   initial begin
      int          exp_cnt;
      int          lat;
      logic [31:0] r;
      int          got;

      vecs[0]  = '{32'hFFFFF800, 3'd0, 32'h00000013, 32'h80000013, 1'b0};
      vecs[1]  = '{32'h00000FFE, 3'd2, 32'h00000063, 32'h7E000FE3, 1'b0};
      vecs[2]  = '{32'h12345001, 3'd3, 32'h00000037, 32'h12345037, 1'b1};
      vecs[3]  = '{32'h12345001, 3'd7, 32'h00000037, 32'h00000037, 1'b1};
      vecs[4]  = '{32'h00000FFF, 3'd2, 32'h00000063, 32'h7E000FE3, 1'b1};
      vecs[5]  = '{32'hFFFFFFFC, 3'd1, 32'h00002023, 32'hFE002E23, 1'b0};
      vecs[6]  = '{32'h00000800, 3'd0, 32'h00000013, 32'h80000013, 1'b1};
      vecs[7]  = '{32'h000FFFFE, 3'd4, 32'h0000006F, 32'h7FFFF06F, 1'b0};
      vecs[8]  = '{32'hFFFFFFFE, 3'd4, 32'h0000006F, 32'hFFFFF06F, 1'b0};
      vecs[9]  = '{32'hABCDE000, 3'd3, 32'h00000FB7, 32'hABCDEFB7, 1'b0};
      vecs[10] = '{32'h00000000, 3'd0, 32'hFFFFFFFF, 32'h000FFFFF, 1'b0};
      vecs[11] = '{32'h00000010, 3'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};

      reset = 1'b1; in_valid = 1'b0; in_imm = '0; in_imm_sel = '0; in_base = '0; out_ready = 1'b1;
      #1;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_out_instr", out_instr, 32'd0);
      chk("reset_out_err", {31'd0, out_err}, 32'd0);
      chk("reset_err_count", {24'd0, err_count}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1 chk("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1 chk("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

      // Table-driven single-word transactions.
      exp_cnt = 0;
      @(negedge clk);
      for (int v = 0; v < 12; v++) begin
         send(vecs[v].imm, vecs[v].sel, vecs[v].base);
         lat = 1;
         while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         chk($sformatf("vec%0d_latency", v), lat, 32'd2);
         chk($sformatf("vec%0d_instr", v), out_instr, vecs[v].instr);
         chk($sformatf("vec%0d_err", v), {31'd0, out_err}, {31'd0, vecs[v].err});
         if (vecs[v].err) exp_cnt++;
         @(negedge clk);
         chk($sformatf("vec%0d_err_count", v), {24'd0, err_count}, exp_cnt);
         $display("vec %0d imm=%08h sel=%0d base=%08h -> instr=%08h err=%0b cnt=%0d",
                  v, vecs[v].imm, vecs[v].sel, vecs[v].base, vecs[v].instr, vecs[v].err, exp_cnt);
      end

      // Backpressure: two words buffered, third held, then drained in order.
      out_ready = 1'b0;
      in_valid = 1'b1; in_imm_sel = 3'd0; in_base = 32'h13; in_imm = 32'd1;
      #1 chk("bp_ready_w0", {31'd0, in_ready}, 32'd1);
      @(negedge clk); in_imm = 32'd2;
      #1 chk("bp_ready_w1", {31'd0, in_ready}, 32'd1);
      @(negedge clk); in_imm = 32'd3;
      for (int c = 0; c < 3; c++) begin
         #1 chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_instr", out_instr, 32'h00100013);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 chk("bp_ready_release", {31'd0, in_ready}, 32'd1);
      chk("bp_out_w0", out_instr, 32'h00100013);
      @(negedge clk); in_valid = 1'b0;
      #1 chk("bp_valid_w1", {31'd0, out_valid}, 32'd1);
      chk("bp_out_w1", out_instr, 32'h00200013);
      @(negedge clk);
      #1 chk("bp_valid_w2", {31'd0, out_valid}, 32'd1);
      chk("bp_out_w2", out_instr, 32'h00300013);
      @(negedge clk);
      #1 chk("bp_drained", {31'd0, out_valid}, 32'd0);
      chk("bp_err_count", {24'd0, err_count}, exp_cnt);
      $display("backpressure sequence done");

      // Saturation: stream 300 illegal-select words.
      in_valid = 1'b1; in_imm_sel = 3'd6; in_base = 32'h0; in_imm = 32'h0;
      repeat (300) @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("sat_err_count", {24'd0, err_count}, 32'd255);
      $display("saturation err_count=%0d", err_count);

      // Fill both stages, then reset asynchronously between edges.
      out_ready = 1'b0; in_valid = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk("full_out_valid", {31'd0, out_valid}, 32'd1);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      #1 reset = 1'b1;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_out_instr", out_instr, 32'd0);
      chk("async_out_err", {31'd0, out_err}, 32'd0);
      chk("async_err_count", {24'd0, err_count}, 32'd0);
      chk("async_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk); reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("post_reset_err_count", {24'd0, err_count}, 32'd0);
      $display("reset with full pipeline done");

      // Round trip: random representable immediates, decoded by the reference generator.
      for (int i = 0; i < NRT; i++) begin
         r = $urandom;
         rt_sel[i]  = 3'(i / 1000);
         rt_base[i] = $urandom;
         case (rt_sel[i])
            3'd0, 3'd1: rt_imm[i] = {{20{r[11]}}, r[11:0]};
            3'd2:       rt_imm[i] = {{19{r[12]}}, r[12:1], 1'b0};
            3'd3:       rt_imm[i] = {r[31:12], 12'b0};
            default:    rt_imm[i] = {{11{r[20]}}, r[20:1], 1'b0};
         endcase
      end
      got = 0;
      fork
         begin : driver
            int i = 0;
            int guard = 0;
            while (i < NRT && guard < 30000) begin
               @(negedge clk);
               guard++;
               in_valid = 1'b1; in_imm = rt_imm[i]; in_imm_sel = rt_sel[i]; in_base = rt_base[i];
               #1;
               if (in_ready) begin
                  exp_q.push_back(i);
                  i++;
               end
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin : monitor
            int guard = 0;
            int idx;
            logic [31:0] dec;
            while (got < NRT && guard < 35000) begin
               @(negedge clk);
               guard++;
               out_ready = ($urandom_range(0, 3) != 0);
               #2;
               if (out_valid && out_ready) begin
                  if (exp_q.size() == 0) begin
                     chk("rt_unexpected_word", 32'd1, 32'd0);
                  end else begin
                     idx = exp_q.pop_front();
                     dec = decode(out_instr, rt_sel[idx]);
                     chk($sformatf("rt%0d_sel%0d_decode", idx, rt_sel[idx]), dec, rt_imm[idx]);
                     chk($sformatf("rt%0d_err", idx), {31'd0, out_err}, 32'd0);
                     if (idx % 1000 == 0)
                        $display("rt %0d sel=%0d imm=%08h instr=%08h", idx, rt_sel[idx], rt_imm[idx], out_instr);
                  end
                  got++;
               end
            end
            out_ready = 1'b1;
         end
      join
      chk("rt_word_count", got, NRT);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
